kernel_window_feeder: RTL
=========================

# kernel_window_feeder

Streaming producer for the 3x3 convolution kernel stage. It accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 shift window. Every time the newest pixel completes a full 3x3 neighbourhood, it presents three 24-bit window rows in exactly the packing the kernel datapath consumes. It sits between the pixel fetch path and the kernel, with valid/ready flow control on both sides.

## Interface
- `IMG_W`, default 64 — pixels per image row, ≥3.
- `IMG_H`, default 64 — rows per frame, ≥3.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `pix_in` in 8 — incoming pixel.
- `pix_valid` in 1 — `pix_in` valid.
- `pix_ready` out 1 — feeder can accept; a pixel transfers when `pix_valid && pix_ready`.
- `win_out[0:2]` out 24 each — window rows; index 0 = oldest (top) row.
- `win_valid` out 1 — `win_out` holds a complete window.
- `win_ready` in 1 — consumer takes the window when `win_valid && win_ready`.
- `win_eof` out 1 — qualifies `win_valid`; set on the last window of a frame.
- `frame_cnt` out 16 — present only with `KFEED_STATS_EN`.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) track the position of the next pixel to be accepted. Both reset to 0.
- On each accepted pixel at (r,c):
  - Line buffer 1 output shifts into line buffer 2.
  - The new pixel enters line buffer 1.
  - The 3x3 shift window shifts left by one column, taking (r-2,c), (r-1,c) and (r,c).
- A window is emitted iff r≥2 and c≥2 ("valid" convolution). A frame produces (IMG_H-2)·(IMG_W-2) windows.
- Window packing for the pixel at (r,c):
  - `win_out[k]` holds image row r-2+k.
  - Bits [7:0] = column c-2, [15:8] = column c-1, [23:16] = column c.
- Window columns are not carried across row boundaries. Windows with c<2 are suppressed, so stale columns are never emitted.
- End of row: `col` wraps to 0 and `row` increments.
- End of frame (r=IMG_H-1, c=IMG_W-1):
  - That window carries `win_eof=1`.
  - Both counters wrap to 0.
  - Line buffers are not cleared; the r≥2 gating makes their old contents harmless.
- Output register is a single stage:
  - `pix_ready = !win_valid || win_ready`.
  - A pixel is never accepted while an unconsumed window is held.
- Arithmetic: pixels are passed unsigned, unmodified. Counters are `$clog2(IMG_W)` and `$clog2(IMG_H)` bits wide.

## Timing
- Reset values:
  - `win_valid=0`, `win_eof=0`, `win_out` all zero.
  - `pix_ready=1` from the first cycle after reset releases.
  - `frame_cnt=0`; counters and window registers are zero.
- Latency: a pixel accepted in cycle t that completes a window gives `win_valid=1` in cycle t+1.
- Simultaneous consume and produce (window taken and a window-completing pixel accepted in the same cycle): `win_valid` stays 1 and `win_out` updates to the new window with no bubble.
- Consume with no new window: `win_valid` drops the next cycle.
- Stall: `win_valid && !win_ready` holds `win_out`, `win_eof` and all counters stable. `pix_ready` is 0.
- `pix_valid` low: no state change.
- Reset mid-frame (`rst_n` low on any edge) discards the partial frame and any held window. The next accepted pixel is (0,0).

## Configuration
- `KFEED_STATS_EN` defined:
  - Adds output `frame_cnt` (16 bit).
  - Increments when a window with `win_eof=1` is consumed; wraps at 16'hFFFF→0.
  - Cleared by reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- `kfeed_pkg` holds:
  - `PIX_W=8` and `ROW_W=24`.
  - typedef `pix_t` (logic [7:0]).
  - typedef `win_row_t` (logic [23:0]).
  - typedef `win_t` (`win_row_t [0:2]`).
- The kernel stage shares this package.
- One sub-module, `kfeed_line_buffer`: an IMG_W-deep, 8-bit delay line with enable, read-before-write. Instantiate it twice.
- The window shift register, counters and handshake stay in the top.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15 streamed with `win_ready=1`:
  - Exactly 4 windows.
  - First window (after pixel 10, cycle t+1): `win_out` = 24'h020100, 24'h060504, 24'h0A0908.
  - Last window: 24'h070605, 24'h0B0A09, 24'h0F0E0D with `win_eof=1`.
- Same stream, `win_ready` held 0 after the first window:
  - `pix_ready` goes 0 and `win_out` stays 24'h020100/060504/0A0908.
  - Release → remaining windows arrive in order, none lost.
- Two back-to-back 4x4 frames with values 0..15 then 100..115: the second frame's first window is 24'h666564, 24'h6A6968, 24'h6E6D6C. Nothing from frame 1 leaks into it.
- Random `pix_valid` gaps (50%) and random `win_ready`: window sequence matches the golden model; `win_eof` appears on exactly every 4th window.
- `rst_n` pulsed low after pixel 9: the next pixels 0..15 yield windows identical to the first test.
- With `KFEED_STATS_EN` and three frames consumed: `frame_cnt`=3. A frame whose eof window is still held does not increment it.

Source files
------------

// File: rtl/kfeed_pkg.sv
// kfeed_pkg: pixel and window types shared by the window feeder and the 3x3 kernel stage.
package kfeed_pkg;
   localparam int PIX_W = 8;
   localparam int ROW_W = 24;
   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [ROW_W-1:0] win_row_t;
   typedef win_row_t [0:2] win_t;
endpackage

// File: rtl/kfeed_line_buffer.sv
// kfeed_line_buffer: DEPTH-deep pixel delay line; dout is the pixel written DEPTH enables ago.
module kfeed_line_buffer
   import kfeed_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   logic [PIX_W-1:0] mem [DEPTH];
   logic [AW-1:0] ptr;
   assign dout = mem[ptr];
   always_ff @(posedge clk)
      if (!rst_n) ptr <= '0;
      else if (en) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
   // storage is never reset: stale contents are masked by the row>=2 gating
   always_ff @(posedge clk)
      if (en) mem[ptr] <= din;
endmodule

// File: rtl/kernel_window_feeder.sv
// kernel_window_feeder: raster pixel stream to 3x3 windows for the kernel stage.
// Define KFEED_STATS_EN to add the frame_cnt output (frames whose eof window was consumed).
module kernel_window_feeder
   import kfeed_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pix_in,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [23:0] win_out [0:2],
   output logic        win_valid,
   input  logic        win_ready,
   output logic        win_eof
`ifdef KFEED_STATS_EN
   ,output logic [15:0] frame_cnt
`endif
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   win_t win;
   pix_t lb1_q, lb2_q;
   logic accept, emit, last_col, last_row;
   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign last_col  = col == CW'(IMG_W - 1);
   assign last_row  = row == RW'(IMG_H - 1);
   assign emit      = row >= RW'(2) && col >= CW'(2);
   assign win_out[0] = win[0];
   assign win_out[1] = win[1];
   assign win_out[2] = win[2];
   kfeed_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .en(accept), .din(pix_in), .dout(lb1_q)
   );
   kfeed_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
      .clk(clk), .rst_n(rst_n), .en(accept), .din(lb1_q), .dout(lb2_q)
   );
   // the shift window doubles as the output register; it only moves on accept, so a stall holds it
   always_ff @(posedge clk)
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         win       <= '0;
         win_valid <= 1'b0;
         win_eof   <= 1'b0;
      end else if (accept) begin
         col       <= last_col ? '0 : col + 1'b1;
         if (last_col) row <= last_row ? '0 : row + 1'b1;
         win[0]    <= {lb2_q, win[0][ROW_W-1:PIX_W]};
         win[1]    <= {lb1_q, win[1][ROW_W-1:PIX_W]};
         win[2]    <= {pix_in, win[2][ROW_W-1:PIX_W]};
         win_valid <= emit;
         win_eof   <= emit && last_col && last_row;
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
`ifdef KFEED_STATS_EN
   always_ff @(posedge clk)
      if (!rst_n) frame_cnt <= '0;
      else if (win_valid && win_ready && win_eof) frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule
